// File: rtl/exe_mem_latch.sv
// exe_mem_latch: EX/MEM pipeline register with stall/flush and registered branch decision.
// Define EXMEM_PERF_CNT_EN to add saturating stall/flush event counters.
module exe_mem_latch #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_add_result,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_rt_data,
    input  logic [REG_W-1:0]  ex_write_reg,
    input  logic              ex_branch,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_branch_target,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic              mem_zero,
    output logic [DATA_W-1:0] mem_rt_data,
    output logic [REG_W-1:0]  mem_write_reg,
    output logic              mem_branch,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_reg_write,
    output logic              mem_mem_to_reg,
    output logic              mem_pc_src
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid         <= 1'b0;
            mem_branch_target <= '0;
            mem_alu_result    <= '0;
            mem_zero          <= 1'b0;
            mem_rt_data       <= '0;
            mem_write_reg     <= '0;
            mem_branch        <= 1'b0;
            mem_mem_read      <= 1'b0;
            mem_mem_write     <= 1'b0;
            mem_reg_write     <= 1'b0;
            mem_mem_to_reg    <= 1'b0;
        end else if (flush) begin
            mem_valid      <= 1'b0;
            mem_branch     <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            mem_valid         <= ex_valid;
            mem_branch_target <= ex_add_result;
            mem_alu_result    <= ex_alu_result;
            mem_zero          <= ex_zero;
            mem_rt_data       <= ex_rt_data;
            mem_write_reg     <= ex_write_reg;
            // Gating with valid keeps bubbles from carrying live control.
            mem_branch        <= ex_branch & ex_valid;
            mem_mem_read      <= ex_mem_read & ex_valid;
            mem_mem_write     <= ex_mem_write & ex_valid;
            mem_reg_write     <= ex_reg_write & ex_valid;
            mem_mem_to_reg    <= ex_mem_to_reg & ex_valid;
        end
    end

    assign mem_pc_src = mem_valid & mem_branch & mem_zero;

`ifdef EXMEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && !flush && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (flush && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_exe_mem_latch.sv
// tb_exe_mem_latch: directed self-checking bench for exe_mem_latch.
module tb_exe_mem_latch;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush, ex_valid, ex_zero;
    logic        ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [31:0] ex_add_result, ex_alu_result, ex_rt_data;
    logic [4:0]  ex_write_reg;
    logic        mem_valid, mem_zero, mem_branch, mem_mem_read, mem_mem_write;
    logic        mem_reg_write, mem_mem_to_reg, mem_pc_src;
    logic [31:0] mem_branch_target, mem_alu_result, mem_rt_data;
    logic [4:0]  mem_write_reg;
`ifdef EXMEM_PERF_CNT_EN
    logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif
    int tests = 0;
    int fails = 0;

    exe_mem_latch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_add_result(ex_add_result), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
        .ex_rt_data(ex_rt_data), .ex_write_reg(ex_write_reg), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .mem_valid(mem_valid), .mem_branch_target(mem_branch_target),
        .mem_alu_result(mem_alu_result), .mem_zero(mem_zero), .mem_rt_data(mem_rt_data),
        .mem_write_reg(mem_write_reg), .mem_branch(mem_branch), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_pc_src(mem_pc_src)
`ifdef EXMEM_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = $urandom; flush = $urandom; ex_valid = 1'b1;
        ex_add_result = $urandom; ex_alu_result = $urandom; ex_rt_data = $urandom;
        ex_write_reg = 5'($urandom); ex_zero = 1'b1; ex_branch = 1'b1; ex_mem_read = 1'b1;
        ex_mem_write = 1'b1; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1;
        step(); step();
        chk("rst_valid", {31'b0, mem_valid}, 32'h0);
        chk("rst_target", mem_branch_target, 32'h0);
        chk("rst_alu", mem_alu_result, 32'h0);
        chk("rst_rt", mem_rt_data, 32'h0);
        chk("rst_wreg", {27'b0, mem_write_reg}, 32'h0);
        chk("rst_ctrl", {26'b0, mem_zero, mem_branch, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg}, 32'h0);
        chk("rst_pcsrc", {31'b0, mem_pc_src}, 32'h0);
`ifdef EXMEM_PERF_CNT_EN
        chk("rst_perf", {perf_stall_cnt, perf_flush_cnt}, 32'h0);
`endif
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0; ex_valid = 1'b1; ex_zero = 1'b0;
        ex_branch = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0;
        ex_mem_to_reg = 1'b0; ex_add_result = 32'h40; ex_alu_result = 32'h0; ex_rt_data = 32'h0;
        ex_write_reg = 5'd0;
        step();
        chk("load_target", mem_branch_target, 32'h40);
        chk("load_valid", {31'b0, mem_valid}, 32'h1);

        ex_branch = 1'b1; ex_zero = 1'b1; ex_add_result = 32'h100;
        step();
        chk("taken_pcsrc", {31'b0, mem_pc_src}, 32'h1);
        chk("taken_target", mem_branch_target, 32'h100);
        stall = 1'b1; ex_zero = 1'b0;
        step();
        chk("stall_pcsrc_hold", {31'b0, mem_pc_src}, 32'h1);
        stall = 1'b0;
        step();
        chk("nottaken_pcsrc", {31'b0, mem_pc_src}, 32'h0);

        ex_branch = 1'b0; ex_alu_result = 32'd30;
        step();
        chk("stall_pre", mem_alu_result, 32'd30);
        stall = 1'b1; ex_alu_result = 32'd40;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", mem_alu_result, 32'd30);
        end
        stall = 1'b0;
        step();
        chk("stall_release", mem_alu_result, 32'd40);

        ex_reg_write = 1'b1; ex_mem_write = 1'b1; ex_alu_result = 32'd50; ex_rt_data = 32'h7; ex_write_reg = 5'd9;
        step();
        chk("flush_pre_ctrl", {30'b0, mem_reg_write, mem_mem_write}, 32'h3);
        flush = 1'b1; ex_alu_result = 32'd60; ex_rt_data = 32'h8; ex_write_reg = 5'd10;
        step();
        chk("flush_valid", {31'b0, mem_valid}, 32'h0);
        chk("flush_ctrl", {27'b0, mem_branch, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg}, 32'h0);
        chk("flush_alu_hold", mem_alu_result, 32'd50);
        chk("flush_data_hold", {mem_rt_data[26:0], mem_write_reg}, {27'h7, 5'd9});
        step();
        chk("flush_again", {30'b0, mem_valid, mem_reg_write}, 32'h0);
        flush = 1'b0;
        step();
        chk("post_flush_load", {mem_alu_result[29:0], mem_valid, mem_reg_write}, {30'd60, 2'b11});
        stall = 1'b1; flush = 1'b1;
        step();
        chk("stall_flush_bubble", {30'b0, mem_valid, mem_reg_write}, 32'h0);
        chk("stall_flush_alu", mem_alu_result, 32'd60);

        stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_branch = 1'b1; ex_zero = 1'b1; ex_mem_write = 1'b0;
        step();
        chk("inv_pcsrc", {31'b0, mem_pc_src}, 32'h0);
        chk("inv_regwrite", {31'b0, mem_reg_write}, 32'h0);
        chk("inv_zero", {31'b0, mem_zero}, 32'h1);

        ex_valid = 1'b1; ex_branch = 1'b0;
        step();
        chk("async_pre", {31'b0, mem_reg_write}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_drop", {31'b0, mem_reg_write}, 32'h0);
        chk("async_valid", {31'b0, mem_valid}, 32'h0);
        step();
        rst_n = 1'b1; ex_valid = 1'b0; ex_reg_write = 1'b0;
`ifdef EXMEM_PERF_CNT_EN
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 2; i++) step();
        chk("perf_stall5", {16'b0, perf_stall_cnt}, 32'd5);
        chk("perf_flush2", {16'b0, perf_flush_cnt}, 32'd2);
        stall = 1'b1;
        step();
        chk("perf_both", {perf_stall_cnt, perf_flush_cnt}, {16'd5, 16'd3});
        flush = 1'b0;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        chk("perf_stall_sat", {16'b0, perf_stall_cnt}, 32'hFFFF);
        stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        chk("perf_flush_sat", {16'b0, perf_flush_cnt}, 32'hFFFF);
        chk("perf_stall_stuck", {16'b0, perf_stall_cnt}, 32'hFFFF);
        flush = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/exe_mem_latch.md
Name: exe_mem_latch

Overview:
EX/MEM pipeline register for the 5-stage MIPS pipeline. It captures the Execute-stage results on each clock edge and presents them to the Memory stage. The captured results are the branch target from the EX adder, the ALU result, the zero flag, the store data, the destination register and the MEM/WB control bits. It also produces the registered branch-taken decision (PCSrc) and target that feed back to the fetch PC mux, and it supports stall (hold) and flush (bubble insertion).

Parameters:
DATA_W, 32, width of branch target, ALU result and store data
REG_W, 5, width of destination register index

Ports:
clk  input  1  pipeline clock, rising-edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold all registered state this cycle
flush  input  1  replace captured instruction with bubble
ex_valid  input  1  EX stage holds a real instruction
ex_add_result  input  DATA_W  branch target from EX adder (PC+4 + offset<<2)
ex_alu_result  input  DATA_W  ALU output / memory address
ex_zero  input  1  ALU zero flag
ex_rt_data  input  DATA_W  store data (forwarded rt)
ex_write_reg  input  REG_W  destination register index
ex_branch  input  1  beq-type branch control
ex_mem_read  input  1  load control
ex_mem_write  input  1  store control
ex_reg_write  input  1  register write-back control
ex_mem_to_reg  input  1  write-back source select
mem_valid  output  1  registered valid
mem_branch_target  output  DATA_W  registered branch target
mem_alu_result  output  DATA_W  registered ALU result
mem_zero  output  1  registered zero flag
mem_rt_data  output  DATA_W  registered store data
mem_write_reg  output  REG_W  registered destination index
mem_branch, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg  output  1 each  registered control
mem_pc_src  output  1  branch taken = mem_valid & mem_branch & mem_zero (combinational from registers)

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, so mem_pc_src=0. Release is sampled at the next rising edge.
- Latency: 1 cycle. Values presented at edge N appear on mem_* after edge N.
- Priority per rising edge: flush > stall > load.
- flush=1: mem_valid and all five control bits are cleared to 0. Data fields (target, ALU, zero, rt_data, write_reg) hold their previous values. flush wins over stall when both are asserted.
- stall=1, flush=0: every register holds its value. mem_pc_src therefore holds as well.
- load (stall=0, flush=0): all fields are captured.
  - If ex_valid=0, control bits and mem_valid are captured as 0. Data is still captured.
- Control outputs are never 1 while mem_valid=0.
- No arithmetic is performed here. Widths pass through unchanged, with no sign or zero extension.
- Reset asserted mid-stall or mid-flush: reset overrides immediately and asynchronously.
- Consecutive flushes: the bubble persists. The first load after a flush captures normally.

Optional Feature:
EXMEM_PERF_CNT_EN
- Defined: adds outputs perf_stall_cnt[15:0] and perf_flush_cnt[15:0].
  - Each counter increments on every rising edge where its condition holds: stall=1 and flush=0 for the stall counter, flush=1 for the flush counter.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst_n.
- Undefined: the ports and logic are absent. Core behaviour is identical.

Test Plan:
- Reset: rst_n=0 with random inputs -> all mem_* = 0, mem_pc_src = 0. Then release and load ex_add_result=32'h0000_0040 with ex_valid=1 -> mem_branch_target = 32'h40 after 1 edge.
- Taken branch: ex_valid=1, ex_branch=1, ex_zero=1, ex_add_result=32'h0000_0100 -> mem_pc_src=1, mem_branch_target=32'h100. Repeat with ex_zero=0 -> mem_pc_src=0.
- Stall hold: load ex_alu_result=32'd30, then stall=1 for 3 edges while ex_alu_result=32'd40 -> mem_alu_result stays 30. Deassert stall -> 40 appears on the next edge.
- Flush: load ex_reg_write=1, ex_mem_write=1, then flush=1 -> mem_valid=0, all control bits 0, mem_alu_result unchanged. With stall=1 and flush=1 together -> the bubble is still inserted.
- Invalid load: ex_valid=0, ex_branch=1, ex_zero=1, ex_reg_write=1 -> mem_pc_src=0, mem_reg_write=0, mem_zero=1.
- Async reset mid-op: assert rst_n=0 between clock edges while mem_reg_write=1 -> the output drops to 0 before the next edge. Under EXMEM_PERF_CNT_EN, 5 stall edges then 2 flush edges -> perf_stall_cnt=5, perf_flush_cnt=2. Preload near saturation -> counters stick at 16'hFFFF.
